uart_rx_frame_deserializer: RTL and testbench

Parametrised UART receive engine that succeeds the fixed 10-bit receive shift block. It oversamples the (optionally looped-back) serial line with a configurable majority-vote filter and runs its own start/data/parity/stop state machine. Frames of 5..DATA_WIDTH bits are assembled LSB first with even, odd or stick parity, and delivered through a holding register with a valid/ready handshake and error flags. It sits between the baud generator (sample_tick source) and the receive FIFO / line-status logic.

---
 rtl/uart_rx_frame_deserializer.sv | 147 ++++++++++++++
 tb/tb_uart_rx_frame_deserializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_deserializer.sv
// uart_rx_frame_deserializer: oversampled UART receiver with majority-vote line filter,
// 5..DATA_WIDTH bit framing, even/odd/stick parity and a valid/ready holding register.
module uart_rx_frame_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int VOTE_TAPS  = 3
) (
    input  logic                            pclk,
    input  logic                            presetn,
    input  logic                            sample_tick,
    input  logic                            uart_rxd,
    input  logic                            loop,
    input  logic                            loop_txd,
    input  logic                            rx_enable,
    input  logic [$clog2(DATA_WIDTH+1)-1:0] word_len,
    input  logic                            pen,
    input  logic                            eps,
    input  logic                            sp,
    input  logic                            rx_ready,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    output logic                            parity_error,
    output logic                            frame_error,
    output logic                            break_detect,
    output logic                            overrun,
    output logic                            rx_busy,
    output logic                            rx_bit
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int WW = $clog2(DATA_WIDTH + 1);
    localparam int VW = $clog2(VOTE_TAPS + 1);
    localparam int SAMPLE_PT = OVERSAMPLE / 2 - 1 + VOTE_TAPS / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t                state, state_nxt;
    logic [VOTE_TAPS-1:0]  vote;
    logic [VW-1:0]         ones;
    logic [CW-1:0]         cnt;
    logic [WW-1:0]         wl, wl_in, nbits;
    logic                  pen_l, eps_l, sp_l;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err, zero;
    logic                  rx_line, at_pt, start_det, load, brk, exp_par;

    assign rx_line   = loop ? loop_txd : uart_rxd;
    assign start_det = (state == IDLE) && sample_tick && rx_enable && !rx_line;
    assign at_pt     = sample_tick && (state != IDLE) && (cnt == CW'(SAMPLE_PT));
    assign wl_in     = (word_len < WW'(5)) ? WW'(5) :
                       (word_len > WW'(DATA_WIDTH)) ? WW'(DATA_WIDTH) : word_len;
    assign exp_par   = sp_l ? ~eps_l : (^shreg) ^ ~eps_l;
    // zero tracks whether every data/parity bit so far was 0, so a low stop bit means break
    assign brk       = !rx_bit && zero;
    assign rx_busy   = state != IDLE;

    always_comb begin
        ones = '0;
        for (int i = 0; i < VOTE_TAPS; i++) ones = ones + VW'(vote[i]);
    end

    assign rx_bit = ones > VW'(VOTE_TAPS / 2);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE:     if (start_det) state_nxt = START;
            START:    if (at_pt) state_nxt = rx_bit ? IDLE : DATA;
            DATA:     if (at_pt && nbits == wl - WW'(1)) state_nxt = pen_l ? PARITY : STOP;
            PARITY:   if (at_pt) state_nxt = STOP;
            STOP: begin
                if (at_pt) begin
                    load      = 1'b1;
                    state_nxt = brk ? BRK_WAIT : IDLE;
                end
            end
            BRK_WAIT: if (rx_bit) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            vote    <= '1;
            cnt     <= '0;
            wl      <= WW'(DATA_WIDTH);
            nbits   <= '0;
            pen_l   <= 1'b0;
            eps_l   <= 1'b0;
            sp_l    <= 1'b0;
            shreg   <= '0;
            par_err <= 1'b0;
            zero    <= 1'b1;
        end else begin
            if (sample_tick) vote <= VOTE_TAPS'({vote, rx_line});
            if (start_det) begin
                cnt     <= '0;
                wl      <= wl_in;
                nbits   <= '0;
                pen_l   <= pen;
                eps_l   <= eps;
                sp_l    <= sp;
                shreg   <= '0;
                par_err <= 1'b0;
                zero    <= 1'b1;
            end else if (sample_tick && state != IDLE) begin
                cnt <= (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + CW'(1);
            end
            if (at_pt && state == DATA) begin
                shreg <= (shreg >> 1) | (DATA_WIDTH'(rx_bit) << (wl - WW'(1)));
                nbits <= nbits + WW'(1);
                zero  <= zero & ~rx_bit;
            end
            if (at_pt && state == PARITY) begin
                par_err <= rx_bit ^ exp_par;
                zero    <= zero & ~rx_bit;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= load && rx_valid && !rx_ready;
            if (load) begin
                rx_data      <= shreg;
                rx_valid     <= 1'b1;
                parity_error <= par_err;
                frame_error  <= !rx_bit;
                break_detect <= brk;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// tb_uart_rx_frame_deserializer: directed vectors and corner-case sequences for the
// UART receive deserializer at default parameters (8 data bits, 16x oversampling, 3-tap vote).
module tb_uart_rx_frame_deserializer;
    logic       pclk = 0, presetn = 0, sample_tick = 0, uart_rxd = 1, loop = 0, loop_txd = 1;
    logic       rx_enable = 1, pen = 0, eps = 0, sp = 0, rx_ready = 0;
    logic [3:0] word_len = 4'd8;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, frame_error, break_detect, overrun, rx_busy, rx_bit;
    int         n_chk = 0, n_fail = 0;
    int         tick_cnt = 0, vt = 0, t0 = 0, ov_cnt = 0, valid_rises = 0, r0, ov0;
    logic       prev_valid = 0, use_loop = 0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] wl;
        int         nb;
        logic       pen, eps, sp, pbit;
        logic [7:0] exp;
        logic       perr;
    } vec_t;
    vec_t v [9];

    uart_rx_frame_deserializer dut (
        .pclk(pclk), .presetn(presetn), .sample_tick(sample_tick), .uart_rxd(uart_rxd),
        .loop(loop), .loop_txd(loop_txd), .rx_enable(rx_enable), .word_len(word_len),
        .pen(pen), .eps(eps), .sp(sp), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_error(parity_error), .frame_error(frame_error),
        .break_detect(break_detect), .overrun(overrun), .rx_busy(rx_busy), .rx_bit(rx_bit)
    );

    always #5 pclk = ~pclk;

    // one sample_tick every 4 pclk, raised and dropped on falling edges
    initial forever begin
        repeat (3) @(negedge pclk);
        sample_tick = 1;
        @(negedge pclk);
        sample_tick = 0;
    end

    always @(posedge pclk) if (sample_tick) tick_cnt <= tick_cnt + 1;

    always @(negedge pclk) begin
        if (rx_valid && !prev_valid) begin
            vt = tick_cnt;
            valid_rises++;
        end
        if (overrun) ov_cnt++;
        prev_valid = rx_valid;
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge pclk);
        while (!sample_tick) @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic drive(logic val, int n);
        if (use_loop) loop_txd = val;
        else          uart_rxd = val;
        repeat (n) wait_tick();
    endtask

    // raise rx_ready for exactly the pclk edge that consumes the next sample_tick
    task automatic ready_on_next_tick();
        repeat (3) @(negedge pclk);
        rx_ready = 1;
        @(negedge pclk);
        rx_ready = 0;
    endtask

    task automatic send_frame(logic [7:0] d, int nb, logic par_en, logic pbit, logic rdy_at_load);
        t0 = tick_cnt;
        drive(0, 16);
        for (int i = 0; i < nb; i++) drive(d[i], 16);
        if (par_en) drive(pbit, 16);
        if (rdy_at_load) begin
            drive(1, 9);
            ready_on_next_tick();
            drive(1, 6);
        end else begin
            drive(1, 16);
        end
    endtask

    task automatic consume(string name);
        @(negedge pclk);
        rx_ready = 1;
        @(negedge pclk);
        rx_ready = 0;
        check({name, " valid cleared"}, rx_valid, 0);
    endtask

    initial begin
        v[0] = '{8'hA5, 4'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        v[1] = '{8'h55, 4'd7, 7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1};
        v[2] = '{8'h55, 4'd7, 7, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0};
        v[3] = '{8'h13, 4'd5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b0};
        v[4] = '{8'h0A, 4'd3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0};
        v[5] = '{8'hC3, 4'd9, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0};
        v[6] = '{8'h81, 4'd8, 8, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0};
        v[7] = '{8'h01, 4'd8, 8, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1};
        v[8] = '{8'h3C, 4'd6, 6, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1};

        repeat (3) @(negedge pclk);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset parity_error", parity_error, 0);
        check("reset frame_error", frame_error, 0);
        check("reset break_detect", break_detect, 0);
        check("reset overrun", overrun, 0);
        check("reset rx_busy", rx_busy, 0);
        check("reset rx_bit", rx_bit, 1);
        presetn = 1;
        drive(1, 8);

        foreach (v[k]) begin
            word_len = v[k].wl;
            pen = v[k].pen;
            eps = v[k].eps;
            sp = v[k].sp;
            send_frame(v[k].d, v[k].nb, v[k].pen, v[k].pbit, 0);
            check($sformatf("vec%0d rx_data", k), rx_data, v[k].exp);
            check($sformatf("vec%0d rx_valid", k), rx_valid, 1);
            check($sformatf("vec%0d parity_error", k), parity_error, v[k].perr);
            check($sformatf("vec%0d frame_error", k), frame_error, 0);
            check($sformatf("vec%0d latency", k), vt - t0 - 1, (1 + v[k].nb + int'(v[k].pen)) * 16 + 9);
            consume($sformatf("vec%0d", k));
            drive(1, 20);
        end
        check("table overrun count", ov_cnt, 0);
        word_len = 4'd8;
        pen = 0;
        eps = 0;
        sp = 0;

        r0 = valid_rises;
        drive(0, 5);
        check("false start busy", rx_busy, 1);
        drive(1, 20);
        check("false start idle", rx_busy, 0);
        check("false start no word", valid_rises - r0, 0);

        drive(0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                drive(1, 8);
                drive(0, 1);
                drive(1, 7);
            end else begin
                drive(1, 16);
            end
        end
        drive(1, 16);
        check("glitch rx_data", rx_data, 8'hFF);
        check("glitch frame_error", frame_error, 0);
        consume("glitch");
        drive(1, 20);

        r0 = valid_rises;
        drive(0, 320);
        check("break word count", valid_rises - r0, 1);
        check("break rx_data", rx_data, 0);
        check("break frame_error", frame_error, 1);
        check("break break_detect", break_detect, 1);
        check("break busy while low", rx_busy, 1);
        drive(1, 20);
        check("break released", rx_busy, 0);
        check("break single word", valid_rises - r0, 1);
        consume("break");
        send_frame(8'h5A, 8, 0, 0, 0);
        check("after break rx_data", rx_data, 8'h5A);
        check("after break frame_error", frame_error, 0);
        check("after break break_detect", break_detect, 0);
        consume("after break");
        drive(1, 20);

        ov0 = ov_cnt;
        send_frame(8'h11, 8, 0, 0, 0);
        send_frame(8'h22, 8, 0, 0, 0);
        check("overrun pulse", ov_cnt - ov0, 1);
        check("overrun rx_data", rx_data, 8'h22);
        check("overrun rx_valid", rx_valid, 1);
        consume("overrun");
        drive(1, 20);
        send_frame(8'h11, 8, 0, 0, 0);
        send_frame(8'h22, 8, 0, 0, 1);
        check("ready at load no overrun", ov_cnt - ov0, 1);
        check("ready at load rx_valid", rx_valid, 1);
        check("ready at load rx_data", rx_data, 8'h22);
        consume("ready at load");
        drive(1, 20);

        send_frame(8'h99, 8, 0, 0, 0);
        drive(0, 16);
        drive(1, 48);
        presetn = 0;
        #1;
        check("mid reset rx_valid", rx_valid, 0);
        check("mid reset rx_data", rx_data, 0);
        check("mid reset rx_busy", rx_busy, 0);
        check("mid reset rx_bit", rx_bit, 1);
        @(negedge pclk);
        presetn = 1;
        drive(1, 20);
        send_frame(8'h3C, 8, 0, 0, 0);
        check("post reset rx_data", rx_data, 8'h3C);
        check("post reset rx_valid", rx_valid, 1);
        consume("post reset");
        drive(1, 20);

        loop = 1;
        use_loop = 1;
        @(negedge pclk);
        uart_rxd = 0;
        drive(1, 8);
        send_frame(8'h96, 8, 0, 0, 0);
        check("loopback rx_data", rx_data, 8'h96);
        check("loopback frame_error", frame_error, 0);
        consume("loopback");
        uart_rxd = 1;
        @(negedge pclk);
        loop = 0;
        use_loop = 0;
        drive(1, 20);

        rx_enable = 0;
        r0 = valid_rises;
        send_frame(8'h77, 8, 0, 0, 0);
        check("disabled no word", valid_rises - r0, 0);
        check("disabled idle", rx_busy, 0);
        rx_enable = 1;
        drive(1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
